// File: rtl/la_ramlib_pkg.sv
// ============================================================
// la_ramlib_pkg : shared helpers for the la_dpram arbiter slice
// Rev 1.0
// ============================================================
`default_nettype none

package la_ramlib_pkg;

  localparam logic LA_REQ_RD = 1'b0;
  localparam logic LA_REQ_WR = 1'b1;

  // Round-robin pointer width; a single requester still needs one bit.
  function automatic int LA_RR_PTRW(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/la_rrarb.sv
// ============================================================
// la_rrarb : N-way round-robin arbiter, one-hot grant
// Rev 1.0
// ============================================================
`default_nettype none

module la_rrarb
  import la_ramlib_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = LA_RR_PTRW(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Two passes: requesters at or above the pointer first, then the wrapped ones.
  always_comb begin
    logic found;
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (j >= int'(ptr_q))) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
        ptr_d  = (j == N - 1) ? '0 : PW'(j + 1);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (j < int'(ptr_q))) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
        ptr_d  = (j == N - 1) ? '0 : PW'(j + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

`default_nettype wire

// File: rtl/la_dpram_arb.sv
// ============================================================
// la_dpram_arb : N-requester write/read arbiter for la_dpram
// Option macro: LA_DPRAM_ARB_FWD_EN (same-address write-to-read forwarding)
// Rev 1.0
// ============================================================
`default_nettype none

module la_dpram_arb
  import la_ramlib_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [N-1:0]  req_valid,
  output logic [N-1:0]  req_ready,
  input  logic [N-1:0]  req_write,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_wmask,
  input  logic [N*DW-1:0] req_din,
  output logic [N-1:0]  rsp_valid,
  output logic [DW-1:0] rsp_dout,
  output logic          ram_wr_ce,
  output logic          ram_wr_we,
  output logic [DW-1:0] ram_wr_wmask,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_wr_din,
  output logic          ram_rd_ce,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_dout
);

  logic [N-1:0] cand_w;
  logic [N-1:0] cand_r;
  logic [N-1:0] gnt_w;
  logic [N-1:0] gnt_r;
  logic [N-1:0] rsp_id_q;
  logic [N-1:0] rsp_id_d;
  logic [DW-1:0] rd_data;

  // Requests are masked while reset is held so nothing is granted during reset.
  always_comb begin
    cand_w = '0;
    cand_r = '0;
    for (int i = 0; i < N; i++) begin
      cand_w[i] = nreset && req_valid[i] && (req_write[i] == LA_REQ_WR);
      cand_r[i] = nreset && req_valid[i] && (req_write[i] == LA_REQ_RD);
    end
  end

  la_rrarb #(.N(N)) u_wr_arb (.clk(clk), .nreset(nreset), .req(cand_w), .gnt(gnt_w));
  la_rrarb #(.N(N)) u_rd_arb (.clk(clk), .nreset(nreset), .req(cand_r), .gnt(gnt_r));

  assign req_ready = gnt_w | gnt_r;

  always_comb begin
    ram_wr_ce    = |gnt_w;
    ram_wr_we    = |gnt_w;
    ram_wr_addr  = '0;
    ram_wr_din   = '0;
    ram_wr_wmask = '0;
    ram_rd_ce    = |gnt_r;
    ram_rd_addr  = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_w[i]) begin
        ram_wr_addr  = req_addr[i*AW +: AW];
        ram_wr_din   = req_din[i*DW +: DW];
        ram_wr_wmask = req_wmask[i*DW +: DW];
      end
      if (gnt_r[i]) ram_rd_addr = req_addr[i*AW +: AW];
    end
  end

  assign rsp_id_d = gnt_r;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) rsp_id_q <= '0;
    else         rsp_id_q <= rsp_id_d;
  end

`ifdef LA_DPRAM_ARB_FWD_EN
  logic          fwd_hit_q,   fwd_hit_d;
  logic [DW-1:0] fwd_wdata_q, fwd_wdata_d;
  logic [DW-1:0] fwd_wmask_q, fwd_wmask_d;

  always_comb begin
    fwd_hit_d   = ram_wr_ce && ram_rd_ce && (ram_wr_addr == ram_rd_addr);
    fwd_wdata_d = ram_wr_din;
    fwd_wmask_d = ram_wr_wmask;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fwd_hit_q   <= 1'b0;
      fwd_wdata_q <= '0;
      fwd_wmask_q <= '0;
    end else begin
      fwd_hit_q   <= fwd_hit_d;
      fwd_wdata_q <= fwd_wdata_d;
      fwd_wmask_q <= fwd_wmask_d;
    end
  end

  // The RAM returned pre-write data; merge in the bits written that same cycle.
  assign rd_data = fwd_hit_q ? ((fwd_wdata_q & fwd_wmask_q) | (ram_rd_dout & ~fwd_wmask_q))
                             : ram_rd_dout;
`else
  assign rd_data = ram_rd_dout;
`endif

  assign rsp_valid = rsp_id_q;
  assign rsp_dout  = (|rsp_id_q) ? rd_data : '0;

endmodule

`default_nettype wire
